// File: rtl/spi_device.sv
// SPI target, mode 0, MSB first, 8-bit frames. All pins are oversampled in
// the clk_sys domain; RX and TX bytes are buffered in small valid/ready FIFOs.
//
// state  | meaning
// IDLE   | not selected, SDO tri-stated, SCK edges ignored
// ACTIVE | selected, shifting on synced SCK edges
module spi_device #(
    parameter int          RxDepth  = 4,
    parameter int          TxDepth  = 4,
    parameter logic [7:0]  IdleByte = 8'hFF
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_ni,
    input  logic       spi_sck_i,
    input  logic       spi_cs_ni,
    input  logic       spi_sdi_i,
    output logic       spi_sdo_o,
    output logic       spi_sdo_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       rx_overflow_o,
    output logic       tx_underflow_o,
    output logic       busy_o
);
    localparam int RxAw = $clog2(RxDepth);
    localparam int TxAw = $clog2(TxDepth);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sck_s_q, cs_s_q, sdi_s_q;
    logic            sck_d_q, cs_d_q;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic            sdo_q, sdo_d, sdo_en_q, sdo_en_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            load_tx, tx_pop, rx_push;

    logic [7:0]      rx_mem [RxDepth];
    logic [7:0]      tx_mem [TxDepth];
    logic [RxAw:0]   rx_wr_q, rx_rd_q;
    logic [TxAw:0]   tx_wr_q, tx_rd_q;

    wire sck_sync = sck_s_q[1];
    wire cs_sync  = cs_s_q[1];
    wire sdi_sync = sdi_s_q[1];
    wire sck_rise = sck_sync & ~sck_d_q;
    wire sck_fall = ~sck_sync & sck_d_q;
    wire cs_fall  = cs_d_q & ~cs_sync;

    wire rx_empty = (rx_wr_q == rx_rd_q);
    wire rx_full  = (rx_wr_q[RxAw] != rx_rd_q[RxAw]) && (rx_wr_q[RxAw-1:0] == rx_rd_q[RxAw-1:0]);
    wire tx_empty = (tx_wr_q == tx_rd_q);
    wire tx_full  = (tx_wr_q[TxAw] != tx_rd_q[TxAw]) && (tx_wr_q[TxAw-1:0] == tx_rd_q[TxAw-1:0]);
    wire rx_pop   = !rx_empty && rx_ready_i;
    wire tx_push  = tx_valid_i && !tx_full;
    wire [7:0] tx_head = tx_mem[tx_rd_q[TxAw-1:0]];

    assign rx_valid_o     = !rx_empty;
    assign rx_data_o      = rx_empty ? 8'h00 : rx_mem[rx_rd_q[RxAw-1:0]];
    assign tx_ready_o     = !tx_full;
    assign busy_o         = ~cs_sync;
    assign spi_sdo_o      = sdo_q;
    assign spi_sdo_en_o   = sdo_en_q;
    assign rx_overflow_o  = ovf_q;
    assign tx_underflow_o = unf_q;

    // Two-flop synchronizers plus one delayed copy for edge detection.
    // CS_N idles high so busy_o and the edge detector start deasserted.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sck_s_q <= 2'b00;
            cs_s_q  <= 2'b11;
            sdi_s_q <= 2'b00;
            sck_d_q <= 1'b0;
            cs_d_q  <= 1'b1;
        end else begin
            sck_s_q <= {sck_s_q[0], spi_sck_i};
            cs_s_q  <= {cs_s_q[0], spi_cs_ni};
            sdi_s_q <= {sdi_s_q[0], spi_sdi_i};
            sck_d_q <= sck_sync;
            cs_d_q  <= cs_sync;
        end
    end

    // Next-state, shift and FIFO-handshake logic; CS_N high wins over SCK edges.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        load_tx    = 1'b0;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                if (cs_fall) begin
                    state_d = ACTIVE;
                    load_tx = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_sync) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], sdi_sync};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (rx_full) ovf_d   = 1'b1;
                        else         rx_push = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) load_tx    = 1'b1;
                    else                   tx_shift_d = tx_shift_q << 1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_tx) begin
            if (tx_empty) begin
                tx_shift_d = IdleByte;
                unf_d      = 1'b1;
            end else begin
                tx_shift_d = tx_head;
                tx_pop     = 1'b1;
            end
        end
        sdo_en_d = (state_d == ACTIVE);
        sdo_d    = (state_d == ACTIVE) ? tx_shift_d[7] : 1'b0;
    end

    // Protocol state, shift registers and registered SDO / status pulses.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            sdo_q      <= 1'b0;
            sdo_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            sdo_q      <= sdo_d;
            sdo_en_q   <= sdo_en_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // FIFO pointers; extra MSB distinguishes full from empty.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
            tx_wr_q <= '0;
            tx_rd_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + {{RxAw{1'b0}}, 1'b1};
            if (rx_pop)  rx_rd_q <= rx_rd_q + {{RxAw{1'b0}}, 1'b1};
            if (tx_push) tx_wr_q <= tx_wr_q + {{TxAw{1'b0}}, 1'b1};
            if (tx_pop)  tx_rd_q <= tx_rd_q + {{TxAw{1'b0}}, 1'b1};
        end
    end

    // FIFO storage; contents are only visible through valid pointers.
    always_ff @(posedge clk_sys_i) begin
        if (rx_push) rx_mem[rx_wr_q[RxAw-1:0]] <= {rx_shift_q[6:0], sdi_sync};
        if (tx_push) tx_mem[tx_wr_q[TxAw-1:0]] <= tx_data_i;
    end

endmodule

// File: tb/tb_spi_device.sv
// Bench for spi_device: a behavioural SPI host plus scoreboards for MISO and RX bytes.
module tb_spi_device;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0, cs_n = 1'b1, sdi = 1'b0;
    logic       sdo, sdo_en;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, tx_ready;
    logic       rx_ovf, tx_unf, busy;

    int total = 0;
    int bad   = 0;
    int n_unf = 0;
    int n_ovf = 0;

    logic [7:0] mosi_q[$];
    logic [7:0] miso_exp_q[$];
    logic [7:0] rx_exp_q[$];

    spi_device #(.RxDepth(4), .TxDepth(4), .IdleByte(8'hFF)) dut (
        .clk_sys_i     (clk),
        .rst_sys_ni    (rst_n),
        .spi_sck_i     (sck),
        .spi_cs_ni     (cs_n),
        .spi_sdi_i     (sdi),
        .spi_sdo_o     (sdo),
        .spi_sdo_en_o  (sdo_en),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (rx_ready),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .rx_overflow_o (rx_ovf),
        .tx_underflow_o(tx_unf),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_unf) n_unf <= n_unf + 1;
        if (rx_ovf) n_ovf <= n_ovf + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge clk);
        check("tx_ready_push", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        miso_exp_q.push_back(b);
    endtask

    // Host: SCK period 80 ns (clk/8). Last SCK fall coincides with CS_N rise.
    task automatic spi_xfer(input int nbits);
        logic [7:0] cur, got, exp, mask;
        int bi, k;
        cur = 8'h00;
        got = 8'h00;
        @(negedge clk);
        cs_n = 1'b0;
        #80;
        for (int i = 0; i < nbits; i++) begin
            bi = i % 8;
            if (bi == 0) cur = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'h00;
            sdi = cur[7-bi];
            #40;
            sck = 1'b1;
            got = {got[6:0], sdo};
            if (i == 0) begin
                check("sdo_en_on", {31'd0, sdo_en}, 32'd1);
                check("busy_on", {31'd0, busy}, 32'd1);
            end
            if (bi == 7) begin
                exp = (miso_exp_q.size() > 0) ? miso_exp_q.pop_front() : 8'hxx;
                check("miso", {24'd0, got}, {24'd0, exp});
            end
            #40;
            sck = 1'b0;
            if (i == nbits - 1) cs_n = 1'b1;
        end
        k = nbits % 8;
        if (k != 0) begin
            exp  = (miso_exp_q.size() > 0) ? miso_exp_q.pop_front() : 8'hxx;
            mask = 8'hFF >> (8 - k);
            check("miso_part", {24'd0, got & mask}, {24'd0, exp >> (8 - k)});
        end
        repeat (3) @(posedge clk);
        #1;
        check("sdo_en_off", {31'd0, sdo_en}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic drain_rx(input int n);
        logic [7:0] exp;
        int w;
        for (int j = 0; j < n; j++) begin
            w = 0;
            @(negedge clk);
            while (!rx_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!rx_valid) begin
                check("rx_timeout", 32'd0, 32'd1);
            end else begin
                exp = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
                check("rx_data", {24'd0, rx_data}, {24'd0, exp});
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sdo"},    {31'd0, sdo},      32'd0);
        check({tag, "_sdo_en"}, {31'd0, sdo_en},   32'd0);
        check({tag, "_rxv"},    {31'd0, rx_valid}, 32'd0);
        check({tag, "_rxd"},    {24'd0, rx_data},  32'd0);
        check({tag, "_txr"},    {31'd0, tx_ready}, 32'd1);
        check({tag, "_ovf"},    {31'd0, rx_ovf},   32'd0);
        check({tag, "_unf"},    {31'd0, tx_unf},   32'd0);
        check({tag, "_busy"},   {31'd0, busy},     32'd0);
    endtask

    initial begin
        int u0, o0;
        #23;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte
        u0 = n_unf; o0 = n_ovf;
        push_tx(8'hA5);
        mosi_q.push_back(8'h3C);
        spi_xfer(8);
        check("single_rxv", {31'd0, rx_valid}, 32'd1);
        check("single_rxd", {24'd0, rx_data}, 32'h3C);
        check("single_unf", n_unf - u0, 32'd0);
        check("single_ovf", n_ovf - o0, 32'd0);
        rx_exp_q.push_back(8'h3C);
        drain_rx(1);

        // Burst
        u0 = n_unf;
        push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
        mosi_q.push_back(8'h01); mosi_q.push_back(8'h02); mosi_q.push_back(8'h03);
        rx_exp_q.push_back(8'h01); rx_exp_q.push_back(8'h02); rx_exp_q.push_back(8'h03);
        spi_xfer(24);
        drain_rx(3);
        check("burst_txr", {31'd0, tx_ready}, 32'd1);
        check("burst_unf", n_unf - u0, 32'd0);

        // Underflow
        u0 = n_unf;
        miso_exp_q.push_back(8'hFF); miso_exp_q.push_back(8'hFF);
        mosi_q.push_back(8'h81); mosi_q.push_back(8'h7E);
        rx_exp_q.push_back(8'h81); rx_exp_q.push_back(8'h7E);
        spi_xfer(16);
        check("unf_count", n_unf - u0, 32'd2);
        drain_rx(2);

        // Overflow
        o0 = n_ovf;
        for (int b = 1; b <= 5; b++) begin
            mosi_q.push_back(8'(b));
            miso_exp_q.push_back(8'hFF);
            if (b <= 4) rx_exp_q.push_back(8'(b));
        end
        spi_xfer(40);
        check("ovf_count", n_ovf - o0, 32'd1);
        drain_rx(4);
        check("ovf_empty", {31'd0, rx_valid}, 32'd0);

        // Abort mid-byte
        push_tx(8'h5A); push_tx(8'hC3);
        mosi_q.push_back(8'hF0);
        spi_xfer(5);
        check("abort_rxv", {31'd0, rx_valid}, 32'd0);
        mosi_q.push_back(8'h99);
        rx_exp_q.push_back(8'h99);
        spi_xfer(8);
        drain_rx(1);

        // Reset mid-transfer
        push_tx(8'h77); push_tx(8'h88);
        void'(miso_exp_q.pop_front());
        void'(miso_exp_q.pop_front());
        u0 = n_unf; o0 = n_ovf;
        @(negedge clk);
        cs_n = 1'b0;
        #80;
        for (int i = 0; i < 3; i++) begin
            sdi = 1'b1;
            #40; sck = 1'b1;
            #40; sck = 1'b0;
        end
        #20;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_unf", n_unf - u0, 32'd0);
        check("midrst_ovf", n_ovf - o0, 32'd0);
        u0 = n_unf;
        miso_exp_q.push_back(8'hFF);
        mosi_q.push_back(8'h42);
        rx_exp_q.push_back(8'h42);
        spi_xfer(8);
        check("midrst_txempty", n_unf - u0, 32'd1);
        drain_rx(1);

        check("sb_miso_left", miso_exp_q.size(), 32'd0);
        check("sb_rx_left", rx_exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
